spike_event_collector: RTL and testbench
========================================

Name: spike_event_collector

Overview:
- Sits directly downstream of the array of `block` instances. It watches each block's 4-bit `out` bus and records every value change as an event {block index, new value}.
- Events are buffered in a small FIFO and drained through a valid/ready port to the chip IO mux or a host readout.
- The result is change-compressed observation of node activity without a wide parallel output.

Parameters:
- NUM_BLOCKS, 4, number of monitored blocks (power of 2, 2..16)
- DATA_W, 4, width of each block output
- FIFO_DEPTH, 8, event FIFO entries (power of 2, >= 2)
- IDX_W, $clog2(NUM_BLOCKS), derived, width of block index

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- blk_out  in  NUM_BLOCKS*DATA_W  concatenated block outputs; block i at bits [i*DATA_W +: DATA_W]
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts head this cycle
- ev_idx  out  IDX_W  block index of the head event
- ev_val  out  DATA_W  new block value of the head event
- ev_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- ovf  out  1  sticky: at least one event was lost
- ovf_clr  in  1  clears ovf

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk. All state changes on posedge clk.
- Reset values:
  - prev[i]=0, snap[i]=0, pending=0
  - rr_ptr=0, FIFO empty, ev_count=0, ev_valid=0, ev_idx=0, ev_val=0, ovf=0
  - prev=0 matches the blocks' own reset output, so leaving reset does not generate spurious events.
- Change detect, per block i, every edge:
  - chg[i] = (blk_out[i] != prev[i]).
  - prev[i] <= blk_out[i].
  - If chg[i]: snap[i] <= blk_out[i] and pending[i] <= 1.
- Arbitration:
  - Round-robin over the pending vector, using the registered value before the edge. Search starts at rr_ptr.
  - A grant g fires only when the FIFO can accept a push.
  - On a grant, push {g, snap[g]} and set rr_ptr <= (g+1) mod NUM_BLOCKS.
  - pending[g] clears at that edge unless chg[g] is also set in the same cycle; set wins and snap takes the new value.
  - At most one push per cycle.
- Overflow:
  - Condition: chg[i] while pending[i]=1 and i is not granted that cycle.
  - Effect: snap[i] is overwritten with the newer value (latest-wins) and ovf <= 1.
  - ovf_clr clears ovf; a set in the same cycle takes priority over the clear.
- FIFO:
  - Push allowed when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs in the same cycle.
  - Pop when ev_valid && ev_ready.
  - Simultaneous push and pop leaves count unchanged.
  - ev_valid = (count != 0). ev_idx/ev_val are driven from head storage and stay stable while ev_valid && !ev_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - When the FIFO is full with no pop, pending bits hold. Nothing is lost unless a second change arrives on that block (see Overflow).
- Latency:
  - A change present before edge k sets pending after edge k.
  - The earliest push is at edge k+1; ev_valid is high after edge k+1, i.e. 2 cycles.
  - Throughput is 1 event per cycle.
- Mid-operation reset: all pending events and FIFO contents are discarded. prev returns to 0, so any nonzero blk_out present after reset produces an event.
- Width rules: no arithmetic on data. Index is zero-extended binary.

Decomposition:
- Package spike_pkg holds:
  - EVT_W = IDX_W + DATA_W
  - the event struct/bit layout {idx, val} with idx in the MSBs
  - default NUM_BLOCKS/DATA_W
- Sub-module event_fifo (parameters WIDTH, DEPTH):
  - synchronous FIFO with push/full/pop/valid/count
  - supports same-cycle push and pop when full
- Change detect, pending, round-robin and ovf live in the top level.

Test Plan:
- Single change: block 2 changes 0 -> 5 at edge 10 (sampled), ev_ready=1 -> ev_valid first high after edge 11 with ev_idx=2, ev_val=5; popped at edge 12; count returns to 0.
- Simultaneous: blocks 0, 1, 3 change to 1, 2, 3 in one cycle with rr_ptr=0 -> events emerge in order idx 0, 1, 3 on consecutive cycles; rr_ptr=0 afterwards.
- Round-robin fairness: blocks 0 and 1 toggle every cycle, rr_ptr starts at 1 -> grants alternate 1, 0, 1, 0; neither is starved.
- Backpressure/full: ev_ready=0, 9 distinct single-block changes spread over blocks 0-3 -> count saturates at 8; the extra change stays pending; ovf stays 0 unless a pending block changes again. Then ev_ready=1 -> all events drain in order.
- Overflow: ev_ready=0 with FIFO full; block 1 changes 0 -> 3 then 3 -> 7 -> ovf=1; after draining, one idx=1 event with val=7 appears; ovf_clr pulse -> ovf=0.
- Reset mid-stream: 5 events queued, rst_n low for 1 cycle while blk_out[0]=4 -> count=0, ev_valid=0; after reset, a single idx=0, val=4 event appears within 2 cycles.

Source files
------------

// File: rtl/spike_pkg.sv
// Shared widths and event layout for the spike event collector.
// An event is {block index, new block value} with the index in the MSBs.
package spike_pkg;

    localparam int NUM_BLOCKS_DEF = 4;
    localparam int DATA_W_DEF     = 4;
    localparam int EVT_IDX_W      = $clog2(NUM_BLOCKS_DEF);
    localparam int EVT_W          = EVT_IDX_W + DATA_W_DEF;

    // Event layout at the default sizes; the top level packs the same
    // {idx, val} order at its own parameterised widths.
    typedef struct packed {
        logic [EVT_IDX_W-1:0]  idx;
        logic [DATA_W_DEF-1:0] val;
    } event_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous event FIFO. A push is accepted when not full, or when full
// and a pop happens in the same cycle. The head reads as zero while empty.
module event_fifo
    import spike_pkg::*;
#(
    parameter int  WIDTH = EVT_W,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    // Entry storage carries no reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/spike_event_collector.sv
// Watches every block output, records each value change as {idx, val},
// picks one pending block per cycle round-robin and queues it in a FIFO
// drained through a valid/ready port. A second change on a block whose
// previous event is still pending overwrites it and sets the sticky ovf.
module spike_event_collector
    import spike_pkg::*;
#(
    parameter int  NUM_BLOCKS = NUM_BLOCKS_DEF,
    parameter int  DATA_W     = DATA_W_DEF,
    parameter int  FIFO_DEPTH = 8,
    localparam int IDX_W      = $clog2(NUM_BLOCKS),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_BLOCKS*DATA_W-1:0] blk_out,
    output logic                         ev_valid,
    input  logic                         ev_ready,
    output logic [IDX_W-1:0]             ev_idx,
    output logic [DATA_W-1:0]            ev_val,
    output logic [CNT_W-1:0]             ev_count,
    output logic                         ovf,
    input  logic                         ovf_clr
);

    localparam int ENT_W = IDX_W + DATA_W;

    logic [DATA_W-1:0]     blk  [NUM_BLOCKS];
    logic [DATA_W-1:0]     prev [NUM_BLOCKS];
    logic [DATA_W-1:0]     snap [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] chg;
    logic [NUM_BLOCKS-1:0] pending;
    logic [NUM_BLOCKS-1:0] gnt_onehot;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      gnt_idx;
    logic [IDX_W-1:0]      cand;
    logic                  gnt_found;
    logic                  grant;
    logic                  pop;
    logic                  can_push;
    logic                  fifo_full;
    logic                  ovf_set;
    logic [ENT_W-1:0]      push_data;
    logic [ENT_W-1:0]      head_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_blk
            assign blk[gi] = blk_out[gi*DATA_W +: DATA_W];
            assign chg[gi] = (blk[gi] != prev[gi]);
        end
    endgenerate

    // Round-robin search over the registered pending vector, starting at rr_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            cand = rr_ptr + IDX_W'(k);
            if (!gnt_found && pending[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign pop       = ev_valid && ev_ready;
    assign can_push  = !fifo_full || pop;
    assign grant     = gnt_found && can_push;
    assign push_data = {gnt_idx, snap[gnt_idx]};

    // One-hot of the block whose event is pushed this cycle (if any).
    always_comb begin
        gnt_onehot = '0;
        if (grant) gnt_onehot[gnt_idx] = 1'b1;
    end

    // A change on a still-pending, ungranted block loses the older value.
    always_comb begin
        ovf_set = |(chg & pending & ~gnt_onehot);
    end

    // Change capture: prev tracks the inputs, snap keeps the latest changed value,
    // and a new change re-arms pending even when the block is granted this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                prev[i] <= '0;
                snap[i] <= '0;
            end
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                prev[i] <= blk[i];
                if (chg[i]) snap[i] <= blk[i];
            end
            pending <= (pending & ~gnt_onehot) | chg;
        end
    end

    // Round-robin pointer moves just past the granted block.
    always_ff @(posedge clk) begin
        if (!rst_n)     rr_ptr <= '0;
        else if (grant) rr_ptr <= gnt_idx + IDX_W'(1);
    end

    // Sticky overflow flag; a new loss outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)       ovf <= 1'b0;
        else if (ovf_set) ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

    event_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant),
        .wdata (push_data),
        .full  (fifo_full),
        .pop   (pop),
        .rdata (head_data),
        .valid (ev_valid),
        .count (ev_count)
    );

    assign {ev_idx, ev_val} = head_data;

endmodule

// File: tb/tb_spike_event_collector.sv
// Scoreboard bench for spike_event_collector: expected events are queued as
// stimulus is applied and compared in order as the consumer accepts them.
module tb_spike_event_collector;

    localparam int NB = 4;
    localparam int DW = 4;
    localparam int FD = 8;
    localparam int IW = 2;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NB*DW-1:0] blk_out;
    logic             ev_valid;
    logic             ev_ready;
    logic [IW-1:0]    ev_idx;
    logic [DW-1:0]    ev_val;
    logic [CW-1:0]    ev_count;
    logic             ovf;
    logic             ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [IW+DW-1:0] exp_q [$];
    logic [IW+DW-1:0] mon_want;

    spike_event_collector #(
        .NUM_BLOCKS (NB),
        .DATA_W     (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .blk_out  (blk_out),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_idx   (ev_idx),
        .ev_val   (ev_val),
        .ev_count (ev_count),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted head must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got idx=%0d val=%0d, required no event", ev_idx, ev_val);
            end else begin
                mon_want = exp_q.pop_front();
                if ({ev_idx, ev_val} !== mon_want) begin
                    n_fail++;
                    $display("FAIL sb_order: got idx=%0d val=%0d, required idx=%0d val=%0d",
                             ev_idx, ev_val, mon_want[IW+DW-1:DW], mon_want[DW-1:0]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_blk(input int i, input logic [DW-1:0] v);
        blk_out[i*DW +: DW] = v;
    endtask

    task automatic expect_ev(input int i, input logic [DW-1:0] v);
        exp_q.push_back({IW'(i), v});
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        blk_out  = '0;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        tick(1);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((ev_count != 0 || exp_q.size() != 0) && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        blk_out  = '0;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        tick(2);
        n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0d, required 0", ev_valid); end
        n_checks++; if (ev_count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d, required 0", ev_count); end
        n_checks++; if (ev_idx !== 2'd0 || ev_val !== 4'd0) begin n_fail++; $display("FAIL rst_head: got %0d/%0d, required 0/0", ev_idx, ev_val); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %0d, required 0", ovf); end
        rst_n = 1'b1;
        tick(3);
        n_checks++; if (ev_valid !== 1'b0 || ev_count !== 4'd0) begin n_fail++; $display("FAIL rst_no_spurious: got valid=%0d count=%0d, required 0/0", ev_valid, ev_count); end
    endtask

    task automatic test_single();
        ev_ready = 1'b1;
        set_blk(2, 4'd5);
        expect_ev(2, 4'd5);
        tick(1);
        n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency1: got valid=%0d, required 0", ev_valid); end
        tick(1);
        n_checks++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0d, required 1", ev_valid); end
        n_checks++; if (ev_idx !== 2'd2 || ev_val !== 4'd5) begin n_fail++; $display("FAIL single_head: got %0d/%0d, required 2/5", ev_idx, ev_val); end
        n_checks++; if (ev_count !== 4'd1) begin n_fail++; $display("FAIL single_count: got %0d, required 1", ev_count); end
        tick(1);
        n_checks++; if (ev_valid !== 1'b0 || ev_count !== 4'd0) begin n_fail++; $display("FAIL single_popped: got valid=%0d count=%0d, required 0/0", ev_valid, ev_count); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        ev_ready = 1'b1;
        set_blk(0, 4'd1); set_blk(1, 4'd2); set_blk(3, 4'd3);
        expect_ev(0, 4'd1); expect_ev(1, 4'd2); expect_ev(3, 4'd3);
        tick(2);
        n_checks++; if (ev_valid !== 1'b1 || ev_idx !== 2'd0) begin n_fail++; $display("FAIL simul_first: got valid=%0d idx=%0d, required 1/0", ev_valid, ev_idx); end
        tick(1);
        n_checks++; if (ev_idx !== 2'd1 || ev_count !== 4'd1) begin n_fail++; $display("FAIL simul_second: got idx=%0d count=%0d, required 1/1", ev_idx, ev_count); end
        tick(1);
        n_checks++; if (ev_idx !== 2'd3 || ev_val !== 4'd3) begin n_fail++; $display("FAIL simul_third: got %0d/%0d, required 3/3", ev_idx, ev_val); end
        tick(1);
        n_checks++; if (ev_count !== 4'd0) begin n_fail++; $display("FAIL simul_empty: got %0d, required 0", ev_count); end
        // Pointer is back at 0: block 0 must win over block 3.
        set_blk(0, 4'd5); set_blk(3, 4'd6);
        expect_ev(0, 4'd5); expect_ev(3, 4'd6);
        tick(2);
        n_checks++; if (ev_idx !== 2'd0 || ev_val !== 4'd5) begin n_fail++; $display("FAIL simul_rr_wrap: got %0d/%0d, required 0/5", ev_idx, ev_val); end
        wait_drain(20);
        n_checks++; if (exp_q.size() != 0 || ev_count !== 4'd0) begin n_fail++; $display("FAIL simul_drain: got left=%0d count=%0d, required 0/0", exp_q.size(), ev_count); end
    endtask

    task automatic test_fairness();
        logic [DW-1:0] a [4];
        logic [DW-1:0] b [4];
        a = '{4'd1, 4'd2, 4'd3, 4'd4};
        b = '{4'd8, 4'd9, 4'd10, 4'd11};
        do_reset();
        ev_ready = 1'b1;
        set_blk(0, 4'd5);
        expect_ev(0, 4'd5);
        tick(4);
        // Grants alternate 1,0,1,0 then the leftover block 1 value.
        expect_ev(1, 4'd8); expect_ev(0, 4'd2); expect_ev(1, 4'd10);
        expect_ev(0, 4'd4); expect_ev(1, 4'd11);
        for (int t = 0; t < 4; t++) begin
            set_blk(0, a[t]);
            set_blk(1, b[t]);
            ovf_clr = (t >= 1);
            tick(1);
        end
        ovf_clr = 1'b0;
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL fair_ovf_set_over_clr: got %0d, required 1", ovf); end
        wait_drain(20);
        n_checks++; if (exp_q.size() != 0 || ev_count !== 4'd0) begin n_fail++; $display("FAIL fair_drain: got left=%0d count=%0d, required 0/0", exp_q.size(), ev_count); end
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL fair_ovf_clr: got %0d, required 0", ovf); end
    endtask

    task automatic test_full();
        int idx_seq [9];
        idx_seq = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        do_reset();
        for (int t = 0; t < 9; t++) begin
            set_blk(idx_seq[t], DW'(t + 1));
            expect_ev(idx_seq[t], DW'(t + 1));
            tick(1);
        end
        tick(2);
        n_checks++; if (ev_count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d, required 8", ev_count); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf: got %0d, required 0", ovf); end
        n_checks++; if (ev_valid !== 1'b1 || ev_idx !== 2'd0 || ev_val !== 4'd1) begin n_fail++; $display("FAIL full_head: got v=%0d %0d/%0d, required 1 0/1", ev_valid, ev_idx, ev_val); end
        tick(1);
        n_checks++; if (ev_idx !== 2'd0 || ev_val !== 4'd1) begin n_fail++; $display("FAIL full_head_stable: got %0d/%0d, required 0/1", ev_idx, ev_val); end
        ev_ready = 1'b1;
        wait_drain(40);
        n_checks++; if (exp_q.size() != 0 || ev_count !== 4'd0) begin n_fail++; $display("FAIL full_drain: got left=%0d count=%0d, required 0/0", exp_q.size(), ev_count); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL full_ovf_after: got %0d, required 0", ovf); end
    endtask

    task automatic test_overflow();
        int idx_seq [8];
        int val_seq [8];
        idx_seq = '{0, 2, 3, 0, 2, 3, 0, 2};
        val_seq = '{1, 1, 1, 2, 2, 2, 3, 3};
        do_reset();
        for (int t = 0; t < 8; t++) begin
            set_blk(idx_seq[t], DW'(val_seq[t]));
            expect_ev(idx_seq[t], DW'(val_seq[t]));
            tick(1);
        end
        tick(2);
        n_checks++; if (ev_count !== 4'd8) begin n_fail++; $display("FAIL ovf_fill: got %0d, required 8", ev_count); end
        set_blk(1, 4'd3);
        tick(1);
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_first_change: got %0d, required 0", ovf); end
        set_blk(1, 4'd7);
        expect_ev(1, 4'd7);
        tick(1);
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0d, required 1", ovf); end
        n_checks++; if (ev_count !== 4'd8) begin n_fail++; $display("FAIL ovf_count_hold: got %0d, required 8", ev_count); end
        ev_ready = 1'b1;
        wait_drain(40);
        n_checks++; if (exp_q.size() != 0 || ev_count !== 4'd0) begin n_fail++; $display("FAIL ovf_drain: got left=%0d count=%0d, required 0/0", exp_q.size(), ev_count); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0d, required 1", ovf); end
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0d, required 0", ovf); end
    endtask

    task automatic test_reset_mid();
        int idx_seq [5];
        int val_seq [5];
        idx_seq = '{0, 1, 2, 3, 0};
        val_seq = '{1, 1, 1, 1, 2};
        do_reset();
        for (int t = 0; t < 5; t++) begin
            set_blk(idx_seq[t], DW'(val_seq[t]));
            tick(1);
        end
        tick(2);
        n_checks++; if (ev_count !== 4'd5) begin n_fail++; $display("FAIL midrst_queued: got %0d, required 5", ev_count); end
        blk_out = '0;
        set_blk(0, 4'd4);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        n_checks++; if (ev_count !== 4'd0 || ev_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flush: got count=%0d valid=%0d, required 0/0", ev_count, ev_valid); end
        expect_ev(0, 4'd4);
        ev_ready = 1'b1;
        tick(1);
        n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_latency1: got %0d, required 0", ev_valid); end
        tick(1);
        n_checks++; if (ev_valid !== 1'b1 || ev_idx !== 2'd0 || ev_val !== 4'd4) begin n_fail++; $display("FAIL midrst_event: got v=%0d %0d/%0d, required 1 0/4", ev_valid, ev_idx, ev_val); end
        wait_drain(20);
        n_checks++; if (exp_q.size() != 0 || ev_count !== 4'd0) begin n_fail++; $display("FAIL midrst_drain: got left=%0d count=%0d, required 0/0", exp_q.size(), ev_count); end
    endtask

    initial begin
        rst_n    = 1'b0;
        blk_out  = '0;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_full();
        test_overflow();
        test_reset_mid();
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
